// File: rtl/polar_pkg.sv
// Shared constants, frame-size encoding, FSM state type and index helpers for the polar encoder.
package polar_pkg;

    localparam int unsigned LOG_N_MAX = 9;
    localparam int unsigned N_128     = 128;
    localparam int unsigned N_256     = 256;
    localparam int unsigned N_512     = 512;

    typedef enum logic [1:0] {
        Sel128     = 2'd0,
        Sel256     = 2'd1,
        Sel512     = 2'd2,
        SelIllegal = 2'd3
    } n_sel_e;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StEnc,
        StOut
    } state_e;

    // log2 of the frame size selected by n_sel (illegal code never reaches here)
    function automatic logic [3:0] sel_log_n(input logic [1:0] sel);
        logic [3:0] log_n;
        case (sel)
            Sel128:  log_n = 4'd7;
            Sel256:  log_n = 4'd8;
            default: log_n = 4'd9;
        endcase
        return log_n;
    endfunction

    function automatic int unsigned sel_n(input logic [1:0] sel);
        int unsigned n;
        case (sel)
            Sel128:  n = N_128;
            Sel256:  n = N_256;
            default: n = N_512;
        endcase
        return n;
    endfunction

    // Reverse only the low n bits: full reversal, then shift the result down into place.
    function automatic logic [LOG_N_MAX-1:0] bitrev(input logic [LOG_N_MAX-1:0] idx,
                                                    input logic [3:0]           n);
        logic [LOG_N_MAX-1:0] rev;
        for (int b = 0; b < LOG_N_MAX; b++) begin
            rev[b] = idx[LOG_N_MAX-1-b];
        end
        return rev >> (4'(LOG_N_MAX) - n);
    endfunction

endpackage

// File: rtl/polar_butterfly_stage.sv
// One in-place butterfly stage of the polar transform: v[i] ^= v[i+span] where bit s of i is 0.
module polar_butterfly_stage #(
    parameter int unsigned N_MAX   = 512,
    parameter int unsigned STAGE_W = 4
) (
    input  logic [N_MAX-1:0]   vec_in,
    input  logic [STAGE_W-1:0] stage,
    output logic [N_MAX-1:0]   vec_out
);

    logic [N_MAX-1:0] mask;
    logic [N_MAX-1:0] partner;
    int unsigned      span;

    always_comb begin
        span = 32'd1 << stage;
        mask = '0;
        for (int i = 0; i < N_MAX; i++) begin
            mask[i] = ((i >> stage) & 1) == 0;
        end
        // Shifting down by span lines buf[i+span] up with buf[i]; masked lanes keep their value.
        partner = vec_in >> span;
        vec_out = vec_in ^ (partner & mask);
    end

endmodule

// File: rtl/polar_encoder.sv
// Bit-serial polar encoder (N = 128/256/512) with valid/ready streams on both sides.
// Define POLAR_ENC_BITREV_EN to emit the codeword in bit-reversed index order.
module polar_encoder
    import polar_pkg::*;
#(
    parameter int unsigned N_MAX = 512,
    parameter int unsigned LOG_N = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] n_sel,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_bit,
    output logic       out_last,
    output logic       busy
);

    localparam int unsigned STAGE_W = $clog2(LOG_N + 1);

    state_e             state_q, state_d;
    logic [LOG_N-1:0]   idx_q, idx_d;
    logic [LOG_N-1:0]   last_q, last_d;
    logic [STAGE_W-1:0] log_n_q, log_n_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic [N_MAX-1:0]   frame_q, frame_d;
    logic [N_MAX-1:0]   stage_vec;
    logic [LOG_N-1:0]   rd_idx;

    polar_butterfly_stage #(
        .N_MAX  (N_MAX),
        .STAGE_W(STAGE_W)
    ) u_stage (
        .vec_in (frame_q),
        .stage  (stage_q),
        .vec_out(stage_vec)
    );

`ifdef POLAR_ENC_BITREV_EN
    always_comb rd_idx = LOG_N'(bitrev(LOG_N_MAX'(idx_q), 4'(log_n_q)));
`else
    always_comb rd_idx = idx_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            last_q  <= '0;
            log_n_q <= '0;
            stage_q <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            log_n_q <= log_n_d;
            stage_q <= stage_d;
            frame_q <= frame_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        log_n_d   = log_n_q;
        stage_d   = stage_q;
        frame_d   = frame_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_bit   = 1'b0;
        out_last  = 1'b0;
        busy      = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (start && (n_sel != SelIllegal)) begin
                    state_d = StLoad;
                    idx_d   = '0;
                    log_n_d = STAGE_W'(sel_log_n(n_sel));
                    last_d  = LOG_N'(sel_n(n_sel) - 32'd1);
                end
            end

            StLoad: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    frame_d[idx_q] = in_bit;
                    idx_d          = idx_q + 1'b1;
                    if (idx_q == last_q) begin
                        state_d = StEnc;
                        idx_d   = '0;
                        stage_d = '0;
                    end
                end
            end

            StEnc: begin
                frame_d = stage_vec;
                stage_d = stage_q + 1'b1;
                if (stage_q == log_n_q - 1'b1) begin
                    state_d = StOut;
                    idx_d   = '0;
                end
            end

            StOut: begin
                out_valid = 1'b1;
                out_bit   = frame_q[rd_idx];
                out_last  = (idx_q == last_q);
                if (out_ready) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == last_q) begin
                        state_d = StIdle;
                        idx_d   = '0;
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_polar_encoder.sv
// Directed self-checking bench for polar_encoder: known codewords, random frame vs model,
// backpressure, ignored starts and mid-frame reset.
module tb_polar_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] n_sel = 2'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_bit = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_bit;
    logic       out_last;
    logic       busy;

    int errors = 0;
    int checks = 0;

    polar_encoder #(
        .N_MAX(512),
        .LOG_N(9)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .n_sel    (n_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_bit   (in_bit),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_bit  (out_bit),
        .out_last (out_last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // x[j] = XOR of u[i] over all i whose set bits include those of j, then optional bitrev.
    function automatic logic [511:0] golden(input logic [511:0] u, input int n_len,
                                            input int log_n);
        logic [511:0] x;
        logic [511:0] y;
        logic         acc;
        int           r;
        x = '0;
        y = '0;
        for (int j = 0; j < n_len; j++) begin
            acc = 1'b0;
            for (int i = 0; i < n_len; i++) begin
                if ((i & j) == j) acc = acc ^ u[i];
            end
            x[j] = acc;
        end
        for (int k = 0; k < n_len; k++) begin
            r = k;
`ifdef POLAR_ENC_BITREV_EN
            r = 0;
            for (int b = 0; b < log_n; b++) begin
                if (((k >> b) & 1) == 1) r = r | (1 << (log_n - 1 - b));
            end
`endif
            y[k] = x[r];
        end
        return y;
    endfunction

    task automatic do_start(input logic [1:0] sel);
        start = 1'b1;
        n_sel = sel;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_phase(input int n_len, input logic [511:0] u, input bit rnd,
                              input int poke, output int lat);
        int k   = 0;
        int cyc = 0;
        while (k < n_len && cyc < 8 * n_len) begin
            in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_bit   = u[k];
            if (poke >= 0 && k == poke) begin
                start = 1'b1;
                n_sel = 2'd2;
            end
            if (in_valid && in_ready) k++;
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        in_valid = 1'b0;
        check("load_done", 512'(k), 512'(n_len));
        check("in_ready_drop", 512'(in_ready), 512'(0));
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic out_phase(input int n_len, input logic [511:0] exp, input bit rnd,
                             input int poke, input string tag);
        logic [511:0] got = '0;
        int           j = 0;
        int           cyc = 0;
        int           last_errs = 0;
        int           stall_errs = 0;
        while (j < n_len && cyc < 8 * n_len) begin
            out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (poke >= 0 && j == poke) begin
                start = 1'b1;
                n_sel = 2'd2;
            end
            if (out_valid) begin
                if (out_last !== 1'(j == n_len - 1)) last_errs++;
                if (!out_ready && out_bit !== exp[j]) stall_errs++;
                if (out_ready) begin
                    got[j] = out_bit;
                    j++;
                end
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        out_ready = 1'b0;
        check({tag, "_bits"}, got, exp);
        check({tag, "_count"}, 512'(j), 512'(n_len));
        check({tag, "_last"}, 512'(last_errs), 512'(0));
        check({tag, "_stall"}, 512'(stall_errs), 512'(0));
        check({tag, "_idle"}, 512'({busy, out_valid}), 512'(0));
    endtask

    initial begin
        int           lat;
        int           j;
        int           cyc;
        logic [511:0] u;
        logic [511:0] e;

        repeat (2) @(negedge clk);
        check("reset_outs", 512'({in_ready, out_valid, out_bit, out_last, busy}), 512'(0));
        rst_n = 1'b1;
        @(negedge clk);

        do_start(2'd3);
        check("illegal_sel", 512'({busy, in_ready, out_valid}), 512'(0));

        // N=128 one-hot at 0; stray starts during LOAD and OUT must be ignored
        do_start(2'd0);
        check("load_entry", 512'({busy, in_ready}), 512'(2'b11));
        u = 512'h1;
        e = 512'h1;
        load_phase(128, u, 1'b0, 20, lat);
        check("lat128", 512'(lat), 512'(8));
        out_phase(128, e, 1'b0, 64, "onehot0");

        // N=128 one-hot at 127 -> all ones
        do_start(2'd0);
        u = 512'h1 << 127;
        e = {384'h0, {128{1'b1}}};
        load_phase(128, u, 1'b0, -1, lat);
        out_phase(128, e, 1'b0, -1, "onehot127");

        // N=256 all ones -> single one at 255
        do_start(2'd1);
        u = {256'h0, {256{1'b1}}};
        e = 512'h1 << 255;
        load_phase(256, u, 1'b0, -1, lat);
        check("lat256", 512'(lat), 512'(9));
        out_phase(256, e, 1'b0, -1, "allones256");

        // N=128 one-hot at 1: codeword ones at j=0 and j=1 (natural) or 0 and 64 (bit-reversed)
        do_start(2'd0);
        u = 512'h2;
`ifdef POLAR_ENC_BITREV_EN
        e = 512'h1 | (512'h1 << 64);
`else
        e = 512'h3;
`endif
        load_phase(128, u, 1'b0, -1, lat);
        out_phase(128, e, 1'b0, -1, "onehot1");

        // N=512 random frame with gaps on both sides
        for (int i = 0; i < 512; i++) u[i] = 1'($urandom_range(0, 1));
        e = golden(u, 512, 9);
        do_start(2'd2);
        load_phase(512, u, 1'b1, -1, lat);
        check("lat512", 512'(lat), 512'(10));
        out_phase(512, e, 1'b1, -1, "rand512");

        // Reset during OUT of an N=256 frame after 40 bits
        for (int i = 0; i < 256; i++) u[i] = 1'($urandom_range(0, 1));
        do_start(2'd1);
        load_phase(256, u, 1'b0, -1, lat);
        j   = 0;
        cyc = 0;
        while (j < 40 && cyc < 600) begin
            out_ready = 1'b1;
            if (out_valid) j++;
            @(negedge clk);
            cyc++;
        end
        check("abort_point", 512'(j), 512'(40));
        rst_n = 1'b0;
        #1;
        check("abort_outs", 512'({in_ready, out_valid, out_bit, out_last, busy}), 512'(0));
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        check("post_reset_idle", 512'({busy, out_valid, in_ready}), 512'(0));

        do_start(2'd0);
        u = 512'h1 << 127;
        e = {384'h0, {128{1'b1}}};
        load_phase(128, u, 1'b0, -1, lat);
        check("lat_after_reset", 512'(lat), 512'(8));
        out_phase(128, e, 1'b0, -1, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
